// File: rtl/ifu_fetch_if.sv
// ----------------------------------------------------------------------------
// ifu_fetch_if
// Bundles every non-clock/reset signal of the instruction fetch stage:
//   - execute-stage next-PC input   (pc_in, pc_w_en)
//   - architectural PC output       (pc_out)
//   - memory request channel        (req_valid, req_addr, req_ready)
//   - memory response channel       (rsp_valid, rsp_data, rsp_err)
//   - decode handshake              (inst_valid, inst, inst_ready)
//   - fault reporting               (fetch_fault, fault_cause)
// master: the fetch stage itself. slave: its environment (memory, decode,
// execute).
// ----------------------------------------------------------------------------
interface ifu_fetch_if #(
  parameter int ISA_WIDTH = 32
);
  logic [ISA_WIDTH-1:0] pc_in;
  logic                 pc_w_en;
  logic [ISA_WIDTH-1:0] pc_out;
  logic                 req_valid;
  logic [ISA_WIDTH-1:0] req_addr;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [ISA_WIDTH-1:0] rsp_data;
  logic                 rsp_err;
  logic                 inst_valid;
  logic [ISA_WIDTH-1:0] inst;
  logic                 inst_ready;
  logic                 fetch_fault;
  logic [1:0]           fault_cause;

  modport master (
    input  pc_in, pc_w_en, req_ready, rsp_valid, rsp_data, rsp_err, inst_ready,
    output pc_out, req_valid, req_addr, inst_valid, inst, fetch_fault, fault_cause
  );

  modport slave (
    output pc_in, pc_w_en, req_ready, rsp_valid, rsp_data, rsp_err, inst_ready,
    input  pc_out, req_valid, req_addr, inst_valid, inst, fetch_fault, fault_cause
  );
endinterface

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch stage owning the architectural PC. One instruction is in
// flight at a time: request at PC, wait for the word, hand it to decode, then
// wait for execute to supply the next PC before fetching again.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ifu_fetch_if.master (PC, memory request/response, decode handshake,
//          fault flags)
// Fault causes: 2'b01 misaligned next PC, 2'b10 memory access error. A fault
// parks the stage until reset.
// ----------------------------------------------------------------------------
module ifu_fetch #(
  parameter int                   ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         rst,
  ifu_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
  localparam logic [1:0] CAUSE_RSP_ERR   = 2'b10;

  state_t               r_state;
  logic [ISA_WIDTH-1:0] r_pc;
  logic [ISA_WIDTH-1:0] r_inst;
  logic                 r_inst_valid;
  logic                 r_fetch_fault;
  logic [1:0]           r_fault_cause;

  logic                 w_pc_misaligned;

  // Only word-aligned next PCs are accepted.
  assign w_pc_misaligned = |bus.pc_in[1:0];

  // Fetch sequencing, PC commit, instruction capture and fault recording.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_inst        <= '0;
      r_inst_valid  <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fault_cause <= CAUSE_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end
        S_REQ: begin
          // Address is r_pc, which cannot change here, so it stays stable
          // while the memory stalls.
          if (bus.req_ready) begin
            r_state <= S_WAIT;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_WAIT: begin
          // Only sampled from the cycle after acceptance onward, since the
          // REQ->WAIT edge is the acceptance itself.
          if (bus.rsp_valid) begin
            if (bus.rsp_err) begin
              r_fetch_fault <= 1'b1;
              r_fault_cause <= CAUSE_RSP_ERR;
              r_state       <= S_FAULT;
            end else begin
              r_inst       <= bus.rsp_data;
              r_inst_valid <= 1'b1;
              r_state      <= S_HOLD;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (bus.inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_EXEC;
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_EXEC: begin
          if (bus.pc_w_en) begin
            if (w_pc_misaligned) begin
              r_fetch_fault <= 1'b1;
              r_fault_cause <= CAUSE_MISALIGN;
              r_state       <= S_FAULT;
            end else begin
              r_pc    <= bus.pc_in;
              r_state <= S_REQ;
            end
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_FAULT: begin
          // Absorbing: flags hold, nothing is presented.
          r_inst_valid <= 1'b0;
          r_state      <= S_FAULT;
        end
        default: begin
          // Unreachable encodings recover by restarting the fetch sequence.
          r_inst_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_valid   = (r_state == S_REQ);
  assign bus.req_addr    = r_pc;
  assign bus.pc_out      = r_pc;
  assign bus.inst_valid  = r_inst_valid;
  assign bus.inst        = r_inst;
  assign bus.fetch_fault = r_fetch_fault;
  assign bus.fault_cause = r_fault_cause;

endmodule

// File: tb/tb_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_fetch
// Directed bench for ifu_fetch. The stimulus thread pushes the expected
// request address / instruction word whenever it completes a handshake; a
// separate monitor pops and compares whenever the DUT shows a fired handshake.
// Stimulus changes 2 time units after the rising edge; the monitor samples on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_total;

  logic [31:0] exp_req_q[$];
  logic [31:0] exp_inst_q[$];

  ifu_fetch_if #(.ISA_WIDTH(32)) bus ();

  ifu_fetch #(.ISA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor: every fired handshake must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) begin
        if (exp_req_q.size() == 0) begin
          chk("unexpected_req", bus.req_addr, 32'hXXXX_XXXX);
        end else begin
          chk("req_addr", bus.req_addr, exp_req_q.pop_front());
        end
      end
      if (bus.inst_valid && bus.inst_ready) begin
        if (exp_inst_q.size() == 0) begin
          chk("unexpected_inst", bus.inst, 32'hXXXX_XXXX);
        end else begin
          chk("inst", bus.inst, exp_inst_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic exec_pc(input logic [31:0] v);
    bus.pc_in   = v;
    bus.pc_w_en = 1'b1;
    step();
    bus.pc_w_en = 1'b0;
  endtask

  // One fetch transaction; c returns the cycle on which req_valid was seen.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input int req_stall, input int inst_stall,
                       input bit wen_wait, input bit early_rsp, input bit stop_hold,
                       output int c);
    int n;
    n = 0;
    while (!bus.req_valid && n < 10) begin
      step();
      n++;
    end
    c = cyc;
    if (!bus.req_valid) begin
      chk("req_timeout", {31'd0, bus.req_valid}, 32'd1);
      return;
    end
    chk("req_addr_first", bus.req_addr, addr);
    for (int i = 0; i < req_stall; i++) begin
      step();
      chk("req_stall_valid", {31'd0, bus.req_valid}, 32'd1);
      chk("req_stall_addr", bus.req_addr, addr);
    end
    exp_req_q.push_back(addr);
    bus.req_ready = 1'b1;
    if (early_rsp) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_err   = 1'b1;
    end
    step();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    chk("wait_no_req", {31'd0, bus.req_valid}, 32'd0);
    chk("wait_no_fault", {31'd0, bus.fetch_fault}, 32'd0);
    if (wen_wait) begin
      bus.pc_in   = 32'h8000_0100;
      bus.pc_w_en = 1'b1;
      step();
      bus.pc_w_en = 1'b0;
      chk("wait_wen_ignored", bus.pc_out, addr);
    end
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = data;
    step();
    bus.rsp_valid = 1'b0;
    chk("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("hold_inst", bus.inst, data);
    if (stop_hold) return;
    for (int i = 0; i < inst_stall; i++) begin
      step();
      chk("inst_stall_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("inst_stall_data", bus.inst, data);
    end
    exp_inst_q.push_back(data);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    chk("exec_inst_drop", {31'd0, bus.inst_valid}, 32'd0);
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    chk("arst_pc", bus.pc_out, RST_PC);
    chk("arst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    chk("arst_cause", {30'd0, bus.fault_cause}, 32'd0);
    chk("arst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("arst_inst", bus.inst, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int c_rel, c0, c1, cx;
    n_pass = 0;
    n_total = 0;
    cyc = 0;
    rst = 1'b1;
    bus.pc_in = 32'd0; bus.pc_w_en = 1'b0; bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0; bus.rsp_data = 32'd0; bus.rsp_err = 1'b0;
    bus.inst_ready = 1'b0;
    step();
    step();
    chk("rst_pc", bus.pc_out, RST_PC);
    chk("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    chk("rst_cause", {30'd0, bus.fault_cause}, 32'd0);
    rst = 1'b0;
    c_rel = cyc;
    step();

    // No-stall fetch: request on the first cycle, then 4 cycles per instruction.
    fetch(RST_PC, 32'h0010_0093, 0, 0, 1'b0, 1'b0, 1'b0, c0);
    chk("first_req_cycle", c0 - c_rel, 32'd1);
    exec_pc(32'h8000_0004);
    // Back-pressure, ignored pc_w_en in WAIT, response in the acceptance cycle ignored.
    fetch(32'h8000_0004, 32'h0020_0113, 3, 2, 1'b1, 1'b1, 1'b0, c1);
    chk("throughput", c1 - c0, 32'd4);
    exec_pc(32'h8000_0008);
    fetch(32'h8000_0008, 32'h0030_0193, 0, 0, 1'b0, 1'b0, 1'b0, cx);
    // Self-loop refetches the same address.
    exec_pc(32'h8000_0008);
    fetch(32'h8000_0008, 32'h0040_0213, 0, 0, 1'b0, 1'b0, 1'b0, cx);
    // Wrap-around supplied by pc_in.
    exec_pc(32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0050_0293, 0, 0, 1'b0, 1'b0, 1'b0, cx);
    exec_pc(32'h0000_0000);
    fetch(32'h0000_0000, 32'h0060_0313, 0, 1, 1'b0, 1'b0, 1'b0, cx);

    // Misaligned jump parks the stage; all inputs ignored afterwards.
    exec_pc(32'h8000_0012);
    chk("mis_fault", {31'd0, bus.fetch_fault}, 32'd1);
    chk("mis_cause", {30'd0, bus.fault_cause}, 32'd1);
    chk("mis_pc_kept", bus.pc_out, 32'h0000_0000);
    bus.req_ready = 1'b1; bus.rsp_valid = 1'b1; bus.inst_ready = 1'b1;
    bus.pc_w_en = 1'b1; bus.pc_in = 32'h8000_0020;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("mis_no_req", {31'd0, bus.req_valid}, 32'd0);
      chk("mis_no_inst", {31'd0, bus.inst_valid}, 32'd0);
    end
    chk("mis_pc_final", bus.pc_out, 32'h0000_0000);
    chk("mis_cause_held", {30'd0, bus.fault_cause}, 32'd1);
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.inst_ready = 1'b0;
    bus.pc_w_en = 1'b0;

    // Recover, then a response error.
    async_reset();
    step();
    chk("restart_req", {31'd0, bus.req_valid}, 32'd1);
    exp_req_q.push_back(RST_PC);
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1; bus.rsp_err = 1'b1; bus.rsp_data = 32'h1234_5678;
    step();
    bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0;
    chk("err_fault", {31'd0, bus.fetch_fault}, 32'd1);
    chk("err_cause", {30'd0, bus.fault_cause}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("err_no_inst", {31'd0, bus.inst_valid}, 32'd0);
      chk("err_no_req", {31'd0, bus.req_valid}, 32'd0);
      step();
    end
    async_reset();
    step();

    // Reset while an instruction is held for decode.
    fetch(RST_PC, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 1'b1, cx);
    async_reset();
    step();
    chk("post_hold_req", {31'd0, bus.req_valid}, 32'd1);
    chk("post_hold_no_inst", {31'd0, bus.inst_valid}, 32'd0);
    fetch(RST_PC, 32'h0070_0393, 0, 0, 1'b0, 1'b0, 1'b0, cx);
    step();

    chk("req_q_empty", exp_req_q.size(), 32'd0);
    chk("inst_q_empty", exp_inst_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
